// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Divisor widths up to 32 bits are supported by the helper function.
package clk_div_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_e;

    localparam int unsigned MIN_DIV = 32'd1;

    // ceil(d/2) without forming d+1, so the maximum divisor cannot overflow
    function automatic logic [31:0] half_period(input logic [31:0] d);
        return (d >> 1) + {31'd0, d[0]};
    endfunction

endpackage

// File: rtl/prog_clk_divider.sv
// Fully synchronous programmable clock divider with shadowed divisor.
// Produces a near-50% level, a last-cycle tick and a divisor-change handshake.
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RESET_DIV = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_out,
    output logic             tick,
    output logic             div_ack,
    output logic             div_pending,
    output logic [WIDTH-1:0] div_active
);

    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_D_W = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] RST_D_W = WIDTH'(RESET_DIV);

    div_state_e       state_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] active_r;
    logic [WIDTH-1:0] shadow_r;
    logic             pending_r;
    logic             div_out_r;
    logic             tick_r;
    logic             ack_r;

    logic             start_s;
    logic             wrap_s;
    logic             boundary_s;
    logic             apply_s;
    logic [WIDTH-1:0] d_next_s;
    logic [WIDTH-1:0] p_next_s;
    logic [WIDTH-1:0] half_s;
    logic [WIDTH-1:0] load_val_s;

    // Period boundary detection, divisor selection and next-phase decode
    always_comb begin
        start_s    = 1'b0;
        wrap_s     = 1'b0;
        d_next_s   = active_r;
        p_next_s   = '0;
        load_val_s = div_in;

        start_s    = en && (state_r == IDLE);
        wrap_s     = en && (state_r == RUN) && (p_r == (active_r - ONE_W));
        boundary_s = start_s || wrap_s;
        // pending_r is the pre-edge flag, so a load on a boundary edge waits a period
        apply_s    = boundary_s && pending_r;

        if (apply_s) begin
            d_next_s = shadow_r;
        end else begin
            d_next_s = active_r;
        end

        if (boundary_s) begin
            p_next_s = '0;
        end else begin
            p_next_s = p_r + ONE_W;
        end

        half_s = WIDTH'(half_period(32'(d_next_s)));

        if (div_in == '0) begin
            load_val_s = MIN_D_W;
        end else begin
            load_val_s = div_in;
        end
    end

    // Run/idle FSM, phase counter, active divisor and registered output decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            p_r       <= '0;
            active_r  <= RST_D_W;
            div_out_r <= 1'b0;
            tick_r    <= 1'b0;
            ack_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE:    state_r <= en ? RUN : IDLE;
                RUN:     state_r <= en ? RUN : IDLE;
                default: state_r <= IDLE;
            endcase

            if (en) begin
                p_r       <= p_next_s;
                active_r  <= d_next_s;
                div_out_r <= (p_next_s < half_s);
                tick_r    <= (p_next_s == (d_next_s - ONE_W));
                ack_r     <= apply_s;
            end else begin
                p_r       <= '0;
                div_out_r <= 1'b0;
                tick_r    <= 1'b0;
                ack_r     <= 1'b0;
            end
        end
    end

    // Shadow divisor: last load wins, cleared once applied
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_r  <= '0;
            pending_r <= 1'b0;
        end else begin
            if (div_load) begin
                shadow_r  <= load_val_s;
                pending_r <= 1'b1;
            end else if (apply_s) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    assign div_out     = div_out_r;
    assign tick        = tick_r;
    assign div_ack     = ack_r;
    assign div_pending = pending_r;
    assign div_active  = active_r;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider against a period-level reference model.
module tb_prog_clk_divider;

    localparam int W  = 8;
    localparam int RD = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         div_out;
    logic         tick;
    logic         div_ack;
    logic         div_pending;
    logic [W-1:0] div_active;

    int total = 0;
    int bad   = 0;

    // reference model: position within current period and period length
    int m_run, m_k, m_d, m_shadow, m_pend, m_ack;
    logic         e_out, e_tick, e_ack, e_pend;
    logic [W-1:0] e_act;

    prog_clk_divider #(.WIDTH(W), .RESET_DIV(RD)) dut (
        .clk(clk), .reset(reset), .en(en), .div_in(div_in), .div_load(div_load),
        .div_out(div_out), .tick(tick), .div_ack(div_ack),
        .div_pending(div_pending), .div_active(div_active)
    );

    always #5 clk = ~clk;

    task automatic model_outputs();
        e_out  = (m_run != 0) && (2 * m_k < m_d);
        e_tick = (m_run != 0) && (m_k == m_d - 1);
        e_ack  = (m_ack != 0);
        e_pend = (m_pend != 0);
        e_act  = W'(m_d);
    endtask

    task automatic model_reset();
        m_run = 0; m_k = 0; m_d = RD; m_shadow = 0; m_pend = 0; m_ack = 0;
        model_outputs();
    endtask

    task automatic model_edge();
        int ld_val;
        ld_val = (div_in == '0) ? 1 : int'(div_in);
        if (!en) begin
            m_run = 0; m_k = 0; m_ack = 0;
        end else begin
            m_ack = 0;
            if (m_run == 0 || m_k == m_d - 1) begin
                if (m_pend != 0) begin
                    m_d = m_shadow; m_pend = 0; m_ack = 1;
                end
                m_k = 0;
            end else begin
                m_k = m_k + 1;
            end
            m_run = 1;
        end
        if (div_load) begin
            m_shadow = ld_val; m_pend = 1;
        end
        model_outputs();
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic wait_ack(input string name, input int limit);
        int n = 0;
        while (!e_ack && n < limit) begin
            step();
            n++;
        end
        total++;
        if (!e_ack) begin
            bad++;
            $display("FAIL %s wait: model never applied divisor within %0d cycles", name, limit);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0;
        model_reset();
        step();
        total += 5;
        if (div_out !== 1'b0)      begin bad++; $display("FAIL reset div_out got %b want 0", div_out); end
        if (tick !== 1'b0)         begin bad++; $display("FAIL reset tick got %b want 0", tick); end
        if (div_ack !== 1'b0)      begin bad++; $display("FAIL reset div_ack got %b want 0", div_ack); end
        if (div_pending !== 1'b0)  begin bad++; $display("FAIL reset div_pending got %b want 0", div_pending); end
        if (div_active !== W'(RD)) begin bad++; $display("FAIL reset div_active got %0d want %0d", div_active, RD); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        en = 1'b1;
        repeat (26) begin
            step();
            total += 5;
            if (div_out !== e_out)      begin bad++; $display("FAIL basic div_out got %b want %b", div_out, e_out); end
            if (tick !== e_tick)        begin bad++; $display("FAIL basic tick got %b want %b", tick, e_tick); end
            if (div_ack !== e_ack)      begin bad++; $display("FAIL basic div_ack got %b want %b", div_ack, e_ack); end
            if (div_pending !== e_pend) begin bad++; $display("FAIL basic div_pending got %b want %b", div_pending, e_pend); end
            if (div_active !== e_act)   begin bad++; $display("FAIL basic div_active got %0d want %0d", div_active, e_act); end
        end
    endtask

    task automatic test_load_mid();
        int n = 0;
        while (m_k != 2 && n < 20) begin step(); n++; end
        div_load = 1'b1; div_in = W'(3);
        step();
        div_load = 1'b0;
        repeat (24) begin
            step();
            total += 5;
            if (div_out !== e_out)      begin bad++; $display("FAIL load_mid div_out got %b want %b", div_out, e_out); end
            if (tick !== e_tick)        begin bad++; $display("FAIL load_mid tick got %b want %b", tick, e_tick); end
            if (div_ack !== e_ack)      begin bad++; $display("FAIL load_mid div_ack got %b want %b", div_ack, e_ack); end
            if (div_pending !== e_pend) begin bad++; $display("FAIL load_mid div_pending got %b want %b", div_pending, e_pend); end
            if (div_active !== e_act)   begin bad++; $display("FAIL load_mid div_active got %0d want %0d", div_active, e_act); end
        end
    endtask

    task automatic test_overwrite();
        int n = 0;
        int acks = 0;
        while (m_k != 0 && n < 20) begin step(); n++; end
        div_load = 1'b1; div_in = W'(5);
        step();
        div_in = W'(6);
        step();
        div_load = 1'b0;
        repeat (14) begin
            step();
            if (div_ack === 1'b1) acks++;
            total += 4;
            if (div_out !== e_out)      begin bad++; $display("FAIL overwrite div_out got %b want %b", div_out, e_out); end
            if (tick !== e_tick)        begin bad++; $display("FAIL overwrite tick got %b want %b", tick, e_tick); end
            if (div_pending !== e_pend) begin bad++; $display("FAIL overwrite div_pending got %b want %b", div_pending, e_pend); end
            if (div_active !== e_act)   begin bad++; $display("FAIL overwrite div_active got %0d want %0d", div_active, e_act); end
        end
        total += 2;
        if (acks != 1)               begin bad++; $display("FAIL overwrite ack_count got %0d want 1", acks); end
        if (div_active !== W'(6))    begin bad++; $display("FAIL overwrite final_div got %0d want 6", div_active); end
    endtask

    task automatic test_zero();
        div_load = 1'b1; div_in = '0;
        step();
        div_load = 1'b0;
        wait_ack("zero", 20);
        repeat (8) begin
            step();
            total += 3;
            if (div_out !== 1'b1)     begin bad++; $display("FAIL zero div_out got %b want 1", div_out); end
            if (tick !== 1'b1)        begin bad++; $display("FAIL zero tick got %b want 1", tick); end
            if (div_active !== W'(1)) begin bad++; $display("FAIL zero div_active got %0d want 1", div_active); end
        end
    endtask

    task automatic test_wrap_load();
        int n = 0;
        div_load = 1'b1; div_in = W'(4);
        step();
        div_load = 1'b0;
        wait_ack("wrap_setup", 20);
        while (m_k != 3 && n < 20) begin step(); n++; end
        div_load = 1'b1; div_in = W'(2);
        step();
        div_load = 1'b0;
        repeat (12) begin
            step();
            total += 5;
            if (div_out !== e_out)      begin bad++; $display("FAIL wrap_load div_out got %b want %b", div_out, e_out); end
            if (tick !== e_tick)        begin bad++; $display("FAIL wrap_load tick got %b want %b", tick, e_tick); end
            if (div_ack !== e_ack)      begin bad++; $display("FAIL wrap_load div_ack got %b want %b", div_ack, e_ack); end
            if (div_pending !== e_pend) begin bad++; $display("FAIL wrap_load div_pending got %b want %b", div_pending, e_pend); end
            if (div_active !== e_act)   begin bad++; $display("FAIL wrap_load div_active got %0d want %0d", div_active, e_act); end
        end
    endtask

    task automatic test_idle();
        en = 1'b0;
        step();
        div_load = 1'b1; div_in = W'(7);
        step();
        div_load = 1'b0;
        step();
        total += 3;
        if (div_out !== 1'b0)     begin bad++; $display("FAIL idle div_out got %b want 0", div_out); end
        if (tick !== 1'b0)        begin bad++; $display("FAIL idle tick got %b want 0", tick); end
        if (div_pending !== 1'b1) begin bad++; $display("FAIL idle div_pending got %b want 1", div_pending); end
        en = 1'b1;
        repeat (16) begin
            step();
            total += 5;
            if (div_out !== e_out)      begin bad++; $display("FAIL idle_run div_out got %b want %b", div_out, e_out); end
            if (tick !== e_tick)        begin bad++; $display("FAIL idle_run tick got %b want %b", tick, e_tick); end
            if (div_ack !== e_ack)      begin bad++; $display("FAIL idle_run div_ack got %b want %b", div_ack, e_ack); end
            if (div_pending !== e_pend) begin bad++; $display("FAIL idle_run div_pending got %b want %b", div_pending, e_pend); end
            if (div_active !== e_act)   begin bad++; $display("FAIL idle_run div_active got %0d want %0d", div_active, e_act); end
        end
    endtask

    task automatic test_reset_mid();
        div_load = 1'b1; div_in = W'(3);
        step();
        div_load = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        total += 5;
        if (div_out !== 1'b0)      begin bad++; $display("FAIL reset_mid div_out got %b want 0", div_out); end
        if (tick !== 1'b0)         begin bad++; $display("FAIL reset_mid tick got %b want 0", tick); end
        if (div_ack !== 1'b0)      begin bad++; $display("FAIL reset_mid div_ack got %b want 0", div_ack); end
        if (div_pending !== 1'b0)  begin bad++; $display("FAIL reset_mid div_pending got %b want 0", div_pending); end
        if (div_active !== W'(RD)) begin bad++; $display("FAIL reset_mid div_active got %0d want %0d", div_active, RD); end
        step();
        reset = 1'b0;
        repeat (10) begin
            step();
            total += 3;
            if (div_out !== e_out)    begin bad++; $display("FAIL reset_mid_run div_out got %b want %b", div_out, e_out); end
            if (div_ack !== e_ack)    begin bad++; $display("FAIL reset_mid_run div_ack got %b want %b", div_ack, e_ack); end
            if (div_active !== e_act) begin bad++; $display("FAIL reset_mid_run div_active got %0d want %0d", div_active, e_act); end
        end
    endtask

    task automatic test_max();
        div_load = 1'b1; div_in = W'((1 << W) - 1);
        step();
        div_load = 1'b0;
        wait_ack("max", 40);
        repeat (2 * ((1 << W) - 1) + 4) begin
            step();
            total += 3;
            if (div_out !== e_out)    begin bad++; $display("FAIL max div_out got %b want %b", div_out, e_out); end
            if (tick !== e_tick)      begin bad++; $display("FAIL max tick got %b want %b", tick, e_tick); end
            if (div_active !== e_act) begin bad++; $display("FAIL max div_active got %0d want %0d", div_active, e_act); end
        end
    endtask

    task automatic test_random();
        repeat (600) begin
            en       = ($urandom_range(0, 19) != 0);
            div_load = ($urandom_range(0, 7) == 0);
            div_in   = W'($urandom_range(0, 12));
            step();
            total += 5;
            if (div_out !== e_out)      begin bad++; $display("FAIL random div_out got %b want %b", div_out, e_out); end
            if (tick !== e_tick)        begin bad++; $display("FAIL random tick got %b want %b", tick, e_tick); end
            if (div_ack !== e_ack)      begin bad++; $display("FAIL random div_ack got %b want %b", div_ack, e_ack); end
            if (div_pending !== e_pend) begin bad++; $display("FAIL random div_pending got %b want %b", div_pending, e_pend); end
            if (div_active !== e_act)   begin bad++; $display("FAIL random div_active got %0d want %0d", div_active, e_act); end
        end
        div_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_mid();
        test_overwrite();
        test_zero();
        test_wrap_load();
        test_idle();
        test_reset_mid();
        test_max();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
